// File: rtl/reg_access_master.sv
// Command-to-register-bus bridge: turns valid/ready read, write and RMW commands
// into single-cycle bank accesses and returns one response per command.
module reg_access_master #(
  parameter int addr_size = 8,
  parameter int NUM_ADDR  = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [1:0]           cmd_op_i,
  input  logic [addr_size-1:0] cmd_addr_i,
  input  logic [7:0]           cmd_wdata_i,
  input  logic [7:0]           cmd_mask_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [7:0]           rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic                 acc_en_o,
  output logic                 wr_en_o,
  output logic [addr_size-1:0] addr_o,
  output logic [7:0]           wdata_o,
  input  logic [7:0]           rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_out_en;
  logic [addr_size-1:0] r_addr;
  logic [7:0]           r_wdata;
  logic [7:0]           r_mask;
  logic [7:0]           r_rdata;
  logic                 r_err;

  logic                 w_capture;
  logic                 w_cmd_err;
  logic [7:0]           w_rmw_data;

  assign w_capture  = cmd_valid_i && cmd_ready_o;
  assign w_cmd_err  = (cmd_op_i == 2'b11) || (32'(cmd_addr_i) >= 32'(NUM_ADDR));
  assign w_rmw_data = (r_rdata & ~r_mask) | (r_wdata & r_mask);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // r_out_en keeps cmd_ready_o low until the first edge after reset release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out_en <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 8'h00;
      r_mask   <= 8'h00;
      r_rdata  <= 8'h00;
      r_err    <= 1'b0;
    end else begin
      r_out_en <= 1'b1;
      if (w_capture) begin
        r_addr  <= cmd_addr_i;
        r_wdata <= cmd_wdata_i;
        r_mask  <= cmd_mask_i;
        r_rdata <= 8'h00;
        r_err   <= w_cmd_err;
      end else if ((r_state == S_RD) || (r_state == S_RMW_RD)) begin
        r_rdata <= rdata_i;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_capture) begin
          if (w_cmd_err) begin
            w_state_next = S_RESP;
          end else begin
            case (cmd_op_i)
              2'b00:   w_state_next = S_RD;
              2'b01:   w_state_next = S_WR;
              default: w_state_next = S_RMW_RD;
            endcase
          end
        end
      end
      S_RD:     w_state_next = S_RESP;
      S_WR:     w_state_next = S_RESP;
      S_RMW_RD: w_state_next = S_RMW_WR;
      S_RMW_WR: w_state_next = S_RESP;
      S_RESP: begin
        if (rsp_ready_i) begin
          w_state_next = S_IDLE;
        end
      end
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Outputs decode only state and captured registers, never cmd_* directly.
  always_comb begin
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = 8'h00;
    rsp_err_o   = 1'b0;
    acc_en_o    = 1'b0;
    wr_en_o     = 1'b0;
    addr_o      = '0;
    wdata_o     = 8'h00;
    case (r_state)
      S_IDLE: begin
        cmd_ready_o = r_out_en;
      end
      S_RD, S_RMW_RD: begin
        acc_en_o = 1'b1;
        addr_o   = r_addr;
      end
      S_WR: begin
        acc_en_o = 1'b1;
        wr_en_o  = 1'b1;
        addr_o   = r_addr;
        wdata_o  = r_wdata;
      end
      S_RMW_WR: begin
        acc_en_o = 1'b1;
        wr_en_o  = 1'b1;
        addr_o   = r_addr;
        wdata_o  = w_rmw_data;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = r_rdata;
        rsp_err_o   = r_err;
      end
      default: begin
        cmd_ready_o = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/reg_access_master.md
REG_ACCESS_MASTER -- requirements
Module: reg_access_master

Interface
REQ-001 SHALL have parameter addr_size, default 8: width of the register address bus.
REQ-002 SHALL have parameter NUM_ADDR, default 9: number of implemented addresses (valid range 0..NUM_ADDR-1).
REQ-003 SHALL have port clk_i  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port cmd_valid_i  input  1  command offered.
REQ-006 SHALL have port cmd_ready_o  output  1  command accepted when high together with cmd_valid_i.
REQ-007 SHALL have port cmd_op_i  input  2  operation: 00 read, 01 write, 10 read-modify-write (RMW), 11 reserved.
REQ-008 SHALL have port cmd_addr_i  input  addr_size  target register address.
REQ-009 SHALL have port cmd_wdata_i  input  8  write data.
REQ-010 SHALL have port cmd_mask_i  input  8  RMW bit mask; 1 = bit replaced by cmd_wdata_i.
REQ-011 SHALL have port rsp_valid_o  output  1  response available.
REQ-012 SHALL have port rsp_ready_i  input  1  response consumed when high together with rsp_valid_o.
REQ-013 SHALL have port rsp_rdata_o  output  8  read data (read and RMW: pre-modify value; write: 0).
REQ-014 SHALL have port rsp_err_o  output  1  command rejected: reserved op or address >= NUM_ADDR.
REQ-015 SHALL have port acc_en_o  output  1  register access strobe to the register bank.
REQ-016 SHALL have port wr_en_o  output  1  1 = write, 0 = read; meaningful only when acc_en_o=1.
REQ-017 SHALL have port addr_o  output  addr_size  register address.
REQ-018 SHALL have port wdata_o  output  8  register write data.
REQ-019 SHALL have port rdata_i  input  8  register read data, combinational from the bank during the acc_en_o=1, wr_en_o=0 cycle.

Function
REQ-020 SHALL implement FSM states IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
REQ-021 SHALL drive cmd_ready_o=1 only in IDLE; a command is captured (op, addr, wdata, mask registered) on the cycle with cmd_valid_i=1 and cmd_ready_o=1.
REQ-022 SHALL, on capture, go IDLE->RD (op 00), IDLE->WR (op 01), IDLE->RMW_RD (op 10), or IDLE->RESP with error flag set and no bus access (op 11 or addr >= NUM_ADDR).
REQ-023 SHALL, in RD, drive acc_en_o=1, wr_en_o=0, addr_o=captured addr for exactly one cycle, register rdata_i at the end of that cycle, then go to RESP.
REQ-024 SHALL, in WR, drive acc_en_o=1, wr_en_o=1, addr_o, wdata_o=captured wdata for exactly one cycle, then go to RESP with rsp_rdata_o=0.
REQ-025 SHALL, in RMW_RD, perform a read cycle as in RD, then go to RMW_WR; in RMW_WR, write (old & ~mask) | (wdata & mask) to the same address for one cycle, then go to RESP with rsp_rdata_o=old value.
REQ-026 SHALL hold acc_en_o=0, wr_en_o=0, addr_o=0, wdata_o=0 in IDLE and RESP; bus outputs are registered (no combinational path from cmd_* to bus outputs).
REQ-027 SHALL assert rsp_valid_o=1 only in RESP, hold rsp_rdata_o/rsp_err_o stable while rsp_valid_o=1, and return to IDLE on the cycle rsp_valid_o and rsp_ready_i are both high.
REQ-028 SHALL give latency: capture edge -> rsp_valid_o high after 2 cycles for read/write, 3 cycles for RMW, 1 cycle for error.
REQ-029 SHALL clear rsp_err_o to 0 for every non-error response.
REQ-030 SHALL issue exactly one bus access per read/write and exactly two (read then write, consecutive cycles) per RMW; never more than one acc_en_o cycle per state visit.
REQ-031 SHALL, if rsp_ready_i is already high on RESP entry, complete in that cycle; next command is accepted no earlier than the following cycle (throughput: one command per 3/3/4 cycles minimum).
REQ-032 SHALL ignore cmd_* inputs outside the capture cycle.

Reset
REQ-033 SHALL, while rst_i=1 (asynchronously, including mid-transaction), force state IDLE, cmd_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, acc_en_o=0, wr_en_o=0, addr_o=0, wdata_o=0, and discard any in-flight command.
REQ-034 SHALL drive cmd_ready_o=1 from the first clock edge after rst_i deasserts.

Verification
REQ-035 Write op=01 addr=3 wdata=0xA5 -> one cycle acc_en_o=1 wr_en_o=1 addr_o=3 wdata_o=0xA5; rsp_valid_o 2 cycles after capture, rdata=0, err=0.
REQ-036 Read op=00 addr=3, bank returns 0xA5 -> single acc_en_o=1 wr_en_o=0 cycle; rsp_rdata_o=0xA5, err=0.
REQ-037 RMW op=10 addr=2 wdata=0x40 mask=0xC0, old 0x8F -> read cycle then write cycle with wdata_o=0x4F; rsp_rdata_o=0x8F.
REQ-038 Read addr=NUM_ADDR (9) and op=11 -> no acc_en_o pulse; rsp_err_o=1 one cycle after capture.
REQ-039 Hold rsp_ready_i=0 for 5 cycles after read -> rsp_valid_o and rsp_rdata_o stable, cmd_ready_o=0, no bus activity; completes on rsp_ready_i=1.
REQ-040 Assert rst_i during RMW_RD -> all outputs 0 immediately, no RMW_RD->RMW_WR write cycle occurs; after release, new write completes normally.
